// File: rtl/dcm_sp_bufg_if.sv
`timescale 1ns/10ps
// Generated-clock bundle of the DCM_SP + BUFG model: lock status plus every derived clock.
interface dcm_sp_bufg_if;
    logic locked;
    logic clock_o0;
    logic clock_o90;
    logic clock_o180;
    logic clock_o270;
    logic clock_o2x;
    logic clock_o2x180;
    logic clock_odv;
    logic clock_ofx;

    modport master (
        output locked, clock_o0, clock_o90, clock_o180, clock_o270,
               clock_o2x, clock_o2x180, clock_odv, clock_ofx
    );

    modport slave (
        input  locked, clock_o0, clock_o90, clock_o180, clock_o270,
               clock_o2x, clock_o2x180, clock_odv, clock_ofx
    );
endinterface

// File: rtl/dcm_sp_bufg.sv
`timescale 1ns/10ps
// Behavioural DCM_SP core with its CLK0 fed through a zero-delay BUFG (1X feedback).
// Measures the input period, locks after a run of stable periods, then paces every output edge in time.
module dcm_sp_bufg #(
    parameter int  CLKDV_DIVIDE   = 2,
    parameter int  CLKFX_MULTIPLY = 4,
    parameter int  CLKFX_DIVIDE   = 1,
    parameter int  LOCK_CYCLES    = 4,
    parameter real PERIOD_TOL     = 0.1
) (
    input  logic          clock,
    input  logic          reset,
    dcm_sp_bufg_if.master clk_bus
);

    localparam int S_CLK0 = 0;
    localparam int S_O90  = 1;
    localparam int S_O270 = 2;
    localparam int S_2X   = 3;
    localparam int S_DV   = 4;
    localparam int S_FX   = 5;
    localparam int S_WDOG = 6;

    generate
        if (CLKDV_DIVIDE < 2 || CLKDV_DIVIDE > 16 ||
            CLKFX_MULTIPLY < 2 || CLKFX_MULTIPLY > 32 ||
            CLKFX_DIVIDE < 1 || CLKFX_DIVIDE > 32 ||
            LOCK_CYCLES < 2 || LOCK_CYCLES > 255) begin : g_bad_param
            $error("dcm_sp_bufg: parameter out of range");
        end
    endgenerate

    logic locked_reg;
    logic clk0_reg;
    logic clk2x_reg;
    logic o90_reg;
    logic o270_reg;
    logic odv_reg;
    logic ofx_reg;
    logic clk_fb;

    real  t_last;
    real  t_prev;
    real  t_new;
    bit   have_edge;
    bit   have_period;
    bit   stable;
    int   stable_cnt;
    int   epoch;
    int   edge_id;
    int   dv_k;
    int   fx_k;

    // BUFG: O = I, and its output doubles as the 1X feedback.
    assign clk_bus.clock_o0     = clk0_reg;
    assign clk_fb               = clk_bus.clock_o0;
    assign clk_bus.clock_o180   = locked_reg & ~clk_fb;
    assign clk_bus.clock_o2x    = clk2x_reg;
    assign clk_bus.clock_o2x180 = locked_reg & ~clk2x_reg;
    assign clk_bus.clock_o90    = o90_reg;
    assign clk_bus.clock_o270   = o270_reg;
    assign clk_bus.clock_odv    = odv_reg;
    assign clk_bus.clock_ofx    = ofx_reg;
    assign clk_bus.locked       = locked_reg;

    task automatic clear_outputs();
        clk0_reg  = 1'b0;
        clk2x_reg = 1'b0;
        o90_reg   = 1'b0;
        o270_reg  = 1'b0;
        odv_reg   = 1'b0;
        ofx_reg   = 1'b0;
    endtask

    task automatic drop_lock();
        epoch      = epoch + 1;
        locked_reg = 1'b0;
        clear_outputs();
        stable_cnt = 0;
    endtask

    task automatic drive(input int sel, input logic val);
        case (sel)
            S_CLK0:  clk0_reg  = val;
            S_O90:   o90_reg   = val;
            S_O270:  o270_reg  = val;
            S_2X:    clk2x_reg = val;
            S_DV:    odv_reg   = val;
            S_FX:    ofx_reg   = val;
            default: ;
        endcase
    endtask

    // Deferred edge; bumping epoch (reset or lock loss) silently voids everything still in flight.
    task automatic post(input int sel, input logic val, input real dly, input int ep, input int eid);
        fork
            begin
                #(dly);
                if (ep == epoch) begin
                    if (sel == S_WDOG) begin
                        if (eid == edge_id && locked_reg) drop_lock();
                    end else begin
                        drive(sel, val);
                    end
                end
            end
        join_none
    endtask

    task automatic run_outputs(input real t);
        real p;
        clk0_reg  = 1'b1;
        clk2x_reg = 1'b1;
        post(S_CLK0, 1'b0, t / 2.0, epoch, 0);
        post(S_O90,  1'b1, t / 4.0, epoch, 0);
        post(S_O90,  1'b0, 3.0 * t / 4.0, epoch, 0);
        post(S_O270, 1'b0, t / 4.0, epoch, 0);
        post(S_O270, 1'b1, 3.0 * t / 4.0, epoch, 0);
        post(S_2X,   1'b0, t / 4.0, epoch, 0);
        post(S_2X,   1'b1, t / 2.0, epoch, 0);
        post(S_2X,   1'b0, 3.0 * t / 4.0, epoch, 0);

        // Odd divide ratios fall half-way through the middle input period.
        if (dv_k == 0) odv_reg = 1'b1;
        if (CLKDV_DIVIDE % 2 == 0) begin
            if (dv_k == CLKDV_DIVIDE / 2) odv_reg = 1'b0;
        end else if (dv_k == (CLKDV_DIVIDE - 1) / 2) begin
            post(S_DV, 1'b0, t / 2.0, epoch, 0);
        end
        dv_k = (dv_k + 1 == CLKDV_DIVIDE) ? 0 : dv_k + 1;

        if (fx_k == 0) begin
            p       = t * real'(CLKFX_DIVIDE) / real'(CLKFX_MULTIPLY);
            ofx_reg = 1'b1;
            post(S_FX, 1'b0, p / 2.0, epoch, 0);
            for (int i = 1; i < CLKFX_MULTIPLY; i++) begin
                post(S_FX, 1'b1, real'(i) * p, epoch, 0);
                post(S_FX, 1'b0, real'(i) * p + p / 2.0, epoch, 0);
            end
        end
        fx_k = (fx_k + 1 == CLKFX_DIVIDE) ? 0 : fx_k + 1;

        post(S_WDOG, 1'b0, 2.0 * t, epoch, edge_id);
    endtask

    always begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            epoch       = epoch + 1;
            locked_reg  = 1'b0;
            clear_outputs();
            have_edge   = 1'b0;
            have_period = 1'b0;
            t_prev      = 0.0;
            t_last      = 0.0;
            stable_cnt  = 0;
            dv_k        = 0;
            fx_k        = 0;
        end else begin
            edge_id = edge_id + 1;
            if (!have_edge) begin
                have_edge = 1'b1;
                t_last    = $realtime;
            end else begin
                t_new  = $realtime - t_last;
                t_last = $realtime;
                // The very first measured period has no predecessor and counts as stable.
                stable = !have_period ||
                         (((t_new - t_prev) <= PERIOD_TOL) && ((t_prev - t_new) <= PERIOD_TOL));
                have_period = 1'b1;
                t_prev      = t_new;
                if (locked_reg) begin
                    if (!stable) drop_lock();
                    else         run_outputs(t_new);
                end else if (!stable) begin
                    stable_cnt = 0;
                end else if (stable_cnt >= LOCK_CYCLES) begin
                    dv_k = 0;
                    fx_k = 0;
                    run_outputs(t_new);
                    locked_reg = 1'b1;
                end else begin
                    stable_cnt = stable_cnt + 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcm_sp_bufg.sv
`timescale 1ns/10ps
// Directed timeline for dcm_sp_bufg: lock, phases, duty correction, lock loss, stop and reset pulse.
module tb_dcm_sp_bufg;

    logic clock = 1'b0;
    logic reset = 1'b1;
    bit   run   = 1'b1;
    real  hi_t  = 10.0;
    real  lo_t  = 10.0;
    int   total = 0;
    int   bad   = 0;
    int   fx_rises = 0;
    int   fx_snap  = 0;

    dcm_sp_bufg_if bus_a ();
    dcm_sp_bufg_if bus_b ();

    dcm_sp_bufg dut_a (
        .clock   (clock),
        .reset   (reset),
        .clk_bus (bus_a)
    );

    dcm_sp_bufg #(
        .CLKFX_MULTIPLY (3),
        .CLKFX_DIVIDE   (2)
    ) dut_b (
        .clock   (clock),
        .reset   (reset),
        .clk_bus (bus_b)
    );

    always begin
        if (run) begin
            #(lo_t) clock = 1'b1;
            #(hi_t) clock = 1'b0;
        end else begin
            #1;
        end
    end

    always @(posedge bus_b.clock_ofx) fx_rises++;

    task automatic at(input real t);
        if (t > $realtime) #(t - $realtime);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $realtime);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $realtime);
        end
    endtask

    initial begin
        // Reset from time zero; clock rises at 10, 30, 50, ...
        at(0.5);  reset = 1'b0;
        at(1.0);
        chk("rst_locked", bus_a.locked, 1'b0);
        chk("rst_o0", bus_a.clock_o0, 1'b0);
        chk("rst_o180", bus_a.clock_o180, 1'b0);
        chk("rst_o2x180", bus_a.clock_o2x180, 1'b0);
        chk("rst_ofx", bus_a.clock_ofx, 1'b0);
        at(15.0); reset = 1'b1;

        // Edge 30 timestamps, lock on the 6th edge after release (130).
        at(111.0);  chk("prelock_locked", bus_a.locked, 1'b0);
        at(129.5);  chk("prelock_o0", bus_a.clock_o0, 1'b0); fx_snap = fx_rises;
        at(131.0);
        chk("lock_locked", bus_a.locked, 1'b1);
        chk("lock_o0", bus_a.clock_o0, 1'b1);
        chk("lock_o180", bus_a.clock_o180, 1'b0);
        chk("lock_o90", bus_a.clock_o90, 1'b0);
        chk("lock_o270", bus_a.clock_o270, 1'b0);
        chk("lock_o2x", bus_a.clock_o2x, 1'b1);
        chk("lock_o2x180", bus_a.clock_o2x180, 1'b0);
        chk("lock_odv", bus_a.clock_odv, 1'b1);
        chk("lock_ofx", bus_a.clock_ofx, 1'b1);
        chk("b_locked", bus_b.locked, 1'b1);
        chk("b_ofx_131", bus_b.clock_ofx, 1'b1);
        at(133.0);  chk("ofx_133", bus_a.clock_ofx, 1'b0);
                    chk("o2x_133", bus_a.clock_o2x, 1'b1);
        at(136.0);  chk("o90_136", bus_a.clock_o90, 1'b1);
                    chk("o2x_136", bus_a.clock_o2x, 1'b0);
                    chk("o2x180_136", bus_a.clock_o2x180, 1'b1);
                    chk("ofx_136", bus_a.clock_ofx, 1'b1);
        at(138.0);  chk("b_ofx_138", bus_b.clock_ofx, 1'b0);
        at(141.0);  chk("o0_141", bus_a.clock_o0, 1'b0);
                    chk("o180_141", bus_a.clock_o180, 1'b1);
                    chk("o2x_141", bus_a.clock_o2x, 1'b1);
                    chk("odv_141", bus_a.clock_odv, 1'b1);
        at(145.0);  chk("b_ofx_145", bus_b.clock_ofx, 1'b1);
        at(146.0);  chk("o90_146", bus_a.clock_o90, 1'b0);
                    chk("o270_146", bus_a.clock_o270, 1'b1);
        at(151.0);  chk("o0_151", bus_a.clock_o0, 1'b1);
                    chk("o270_151", bus_a.clock_o270, 1'b1);
                    chk("odv_151", bus_a.clock_odv, 1'b0);
                    chk("b_ofx_151", bus_b.clock_ofx, 1'b0);
        at(156.0);  chk("o270_156", bus_a.clock_o270, 1'b0);
        at(158.0);  chk("b_ofx_158", bus_b.clock_ofx, 1'b1);
        at(165.0);  chk("b_ofx_165", bus_b.clock_ofx, 1'b0);
        at(169.5);  chk_n("b_ofx_rises_window", fx_rises - fx_snap, 3);
        at(171.0);  chk("odv_171", bus_a.clock_odv, 1'b1);
                    chk("b_ofx_realign", bus_b.clock_ofx, 1'b1);

        // 30% input duty from the 190 edge on; output keeps 10 ns high.
        at(185.0);  hi_t = 6.0; lo_t = 14.0;
        at(216.5);  chk("duty_clkin_low", clock, 1'b0);
                    chk("duty_o0_high", bus_a.clock_o0, 1'b1);
        at(219.5);  chk("duty_o0_9p5", bus_a.clock_o0, 1'b1);
        at(220.5);  chk("duty_o0_10p5", bus_a.clock_o0, 1'b0);
                    chk("duty_locked", bus_a.locked, 1'b1);
        at(225.0);  hi_t = 10.0; lo_t = 10.0;

        // Stretch to 25 ns: edge 275 is unstable, relock at 275 + 5*25 = 400.
        at(245.0);  lo_t = 15.0;
        at(274.0);  chk("stretch_before", bus_a.locked, 1'b1);
        at(275.5);  chk("stretch_locked", bus_a.locked, 1'b0);
                    chk("stretch_o0", bus_a.clock_o0, 1'b0);
                    chk("stretch_o2x", bus_a.clock_o2x, 1'b0);
                    chk("stretch_ofx", bus_a.clock_ofx, 1'b0);
                    chk("stretch_o180", bus_a.clock_o180, 1'b0);
        at(285.5);  chk("stretch_no_pulse", bus_a.clock_o0, 1'b0);
        at(399.5);  chk("relock_before", bus_a.locked, 1'b0);
        at(400.5);  chk("relock_locked", bus_a.locked, 1'b1);
                    chk("relock_o0", bus_a.clock_o0, 1'b1);
        at(407.0);  chk("relock_o90", bus_a.clock_o90, 1'b1);

        // Stop after the 450 edge: lock drops 2*25 ns later.
        at(452.0);  run = 1'b0;
        at(499.5);  chk("stop_locked_hold", bus_a.locked, 1'b1);
                    chk("stop_o270_hold", bus_a.clock_o270, 1'b1);
        at(500.5);  chk("stop_locked", bus_a.locked, 1'b0);
                    chk("stop_o270", bus_a.clock_o270, 1'b0);
                    chk("stop_o0", bus_a.clock_o0, 1'b0);

        // Resume at 20 ns: edges 516, 536 unstable, relock at 636.
        at(505.5);  lo_t = 10.0; hi_t = 10.0; run = 1'b1;
        at(635.5);  chk("resume_before", bus_a.locked, 1'b0);
        at(636.5);  chk("resume_locked", bus_a.locked, 1'b1);

        // 3 ns reset pulse while locked; relock at the 6th edge after 643 (756).
        at(640.0);  reset = 1'b0;
        at(640.5);  chk("pulse_locked", bus_a.locked, 1'b0);
                    chk("pulse_o0", bus_a.clock_o0, 1'b0);
                    chk("pulse_odv", bus_a.clock_odv, 1'b0);
                    chk("pulse_o2x180", bus_a.clock_o2x180, 1'b0);
        at(643.0);  reset = 1'b1;
        at(643.5);  chk("pulse_o90_cancel", bus_a.clock_o90, 1'b0);
        at(755.5);  chk("pulse_relock_before", bus_a.locked, 1'b0);
        at(756.5);  chk("pulse_relock", bus_a.locked, 1'b1);
                    chk("pulse_relock_o0", bus_a.clock_o0, 1'b1);
                    chk("pulse_relock_b_ofx", bus_b.clock_ofx, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcm_sp_bufg.md
DCM_SP_BUFG -- requirements
Module: dcm_sp_bufg

Interface
REQ-001 Parameter CLKDV_DIVIDE, default 2, integer 2..16; divide ratio for clock_odv.
REQ-002 Parameter CLKFX_MULTIPLY, default 4, integer 2..32; multiply ratio for clock_ofx.
REQ-003 Parameter CLKFX_DIVIDE, default 1, integer 1..32; divide ratio for clock_ofx.
REQ-004 Parameter LOCK_CYCLES, default 4, integer 2..255; consecutive stable input periods required before lock.
REQ-005 Parameter PERIOD_TOL, default 0.1 (ns, real); maximum period deviation still counted as stable.
REQ-006 clock  input  1  reference clock (CLKIN); one clock; all behaviour is referenced to its rising edges.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 locked  output  1  high while all generated clocks are valid.
REQ-009 clock_o0  output  1  0-degree clock, driven through the internal global buffer (BUFG).
REQ-010 clock_o90 / clock_o180 / clock_o270  output  1 each  copies of clock_o0 shifted by T/4, T/2 and 3T/4.
REQ-011 clock_o2x / clock_o2x180  output  1 each  double-frequency clock and its inverse.
REQ-012 clock_odv  output  1  clock with period T*CLKDV_DIVIDE.
REQ-013 clock_ofx  output  1  clock with period T*CLKFX_DIVIDE/CLKFX_MULTIPLY.

Function
REQ-014 The block SHALL be a behavioural simulation model (timescale 1ns/10ps) containing a DCM core and a BUFG with O = I; BUFG input = core CLK0; BUFG output = clock_o0 and the internal feedback (CLK_FEEDBACK 1X, no phase shift, CLKIN not pre-divided).
REQ-015 T SHALL be measured as the time between consecutive rising edges of clock; a period is stable if |T_new - T_prev| <= PERIOD_TOL.
REQ-016 Acquire state: count stable periods; a non-stable period resets the count to 0.
REQ-017 When the count reaches LOCK_CYCLES, on the next clock rising edge, outputs start and locked rises at that same edge.
REQ-018 All outputs SHALL have 50% duty cycle (duty-cycle correction), independent of input duty.
REQ-019 clock_o0 and clock_o2x rising edges SHALL coincide with clock rising edges; clock_o180 = ~clock_o0 and clock_o2x180 = ~clock_o2x while locked.
REQ-020 clock_odv first rising edge SHALL coincide with the lock edge; thereafter it rises every CLKDV_DIVIDE input periods.
REQ-021 clock_ofx SHALL realign its rising edge to a clock rising edge every CLKFX_DIVIDE input periods, producing exactly CLKFX_MULTIPLY cycles per realignment window.
REQ-022 Loss of lock while locked: a non-stable period, or no clock rising edge within 2*T. Response: locked falls immediately, all clock outputs are forced low, and the block returns to the acquire state with count 0.
REQ-023 Inputs DSSEN, PSEN, PSINCDEC and PSCLK SHALL NOT exist; dynamic phase shift is unsupported.

Reset
REQ-024 reset low SHALL asynchronously force locked and all clock outputs to 0, clear the measured period and stable count, and stop all pending output scheduling.
REQ-025 After reset rises, acquisition SHALL start at the first following clock rising edge (that edge only timestamps; the first period completes on the next edge).
REQ-026 reset asserted mid-operation SHALL behave identically to reset at time zero; no partial output pulse may be emitted after reset falls.

Verification
REQ-027 20 ns clock, reset released at 15 ns, defaults: locked rises at the 6th clock rising edge after release.
REQ-028 Locked, 20 ns clock: clock_o90 rises 5 ns after clock_o0; clock_o270 rises 15 ns after; clock_o2x period 10 ns; clock_ofx period 5 ns; clock_odv period 40 ns; all 50% duty.
REQ-029 Input duty 30%, 20 ns period: clock_o0 high exactly 10 ns per cycle.
REQ-030 Locked, then one period stretched to 25 ns: locked falls at that edge, outputs go low, locked reasserts after LOCK_CYCLES stable 25 ns periods.
REQ-031 Locked, clock stopped: locked falls 40 ns after the last edge and all outputs read 0.
REQ-032 reset pulsed low for 3 ns while locked: locked and all outputs go 0 within the same timestep; full reacquisition follows.
REQ-033 CLKFX_MULTIPLY=3, CLKFX_DIVIDE=2, 20 ns clock: clock_ofx produces 3 rising edges per 40 ns, aligned to every second clock rising edge.
